gf180mcu_sram64x8_ctrl: RTL and testbench
=========================================

# gf180mcu_sram64x8_ctrl

Request/response controller that sits directly upstream of the gf180mcu_fd_ip_sram__sram64x8m8wm1 64x8 macro and drives all of its input pins. It performs the mandatory CEN 1→0 power-up sequence and an optional zero-fill of all 64 words. It then converts a valid/ready request port into correctly timed macro cycles and returns read data on a one-cycle response strobe.

## Interface
- INIT_CYCLES, 4: cycles SRAM_CEN is held high after reset before any macro access (min 1).
- CLEAR_ON_INIT, 1: 1 = write 8'h00 to addresses 0..63 after INIT; 0 = skip.
- CLK  in  1  controller clock. The macro CLK pin is tied to ~CLK at the parent, so the macro samples on CLK falling edges.
- RSTN  in  1  reset, synchronous, active-low.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  controller accepts the request this cycle.
- REQ_WRITE  in  1  1 = write, 0 = read.
- REQ_ADDR  in  6  word address.
- REQ_WDATA  in  8  write data.
- REQ_WMASK  in  8  per-bit write enable, 1 = write.
- RSP_VALID  out  1  one-cycle strobe; RSP_RDATA is valid.
- RSP_RDATA  out  8  read data, held until the next read response.
- INIT_DONE  out  1  high once INIT/CLEAR is complete; sticky until reset.
- SRAM_CEN / SRAM_GWEN  out  1  macro chip enable / global write enable, active-low.
- SRAM_WEN  out  8  macro per-bit write enable, active-low (= ~mask).
- SRAM_A  out  6, SRAM_D  out  8  macro address/data.
- SRAM_Q  in  8  macro read data.

## Operation
- All SRAM_* outputs are registered on the CLK rising edge, giving the macro half a cycle of setup and hold.
- Reset values: REQ_READY 0, RSP_VALID 0, RSP_RDATA 8'h00, INIT_DONE 0, SRAM_CEN 1, SRAM_GWEN 1, SRAM_WEN 8'hFF, SRAM_A 0, SRAM_D 0.
- FSM states: INIT, CLEAR, IDLE, WAIT.
- INIT: SRAM_CEN=1. A counter runs 0..INIT_CYCLES-1, then the FSM goes to CLEAR if CLEAR_ON_INIT, else IDLE.
- CLEAR: one write per cycle with CEN=0, GWEN=0, WEN=8'h00, D=0, A=0..63. This produces the macro's required CEN 1→0 transition. After A=63 is issued: INIT_DONE=1, pins deselected, FSM goes to IDLE.
- IDLE: REQ_READY=1 and pins deselected (CEN=1, GWEN=1, WEN=8'hFF).
  - A handshake (VALID&READY) registers: A=REQ_ADDR, D=REQ_WDATA, WEN=~REQ_WMASK, GWEN=~REQ_WRITE, CEN=0. FSM goes to WAIT.
  - Exception: a write with REQ_WMASK==0 is accepted but leaves CEN=1 (no macro access).
- WAIT: REQ_READY=0. Pins return to the deselected state at the next edge, then the FSM goes to IDLE. Deselected pins hold macro Q stable.
- Read response: rd_pend is set on acceptance. At the 2nd rising edge after acceptance, RSP_RDATA<=SRAM_Q, RSP_VALID<=1 (one cycle), rd_pend cleared.
- Writes produce no response.
- Before INIT_DONE, REQ_READY=0 and requests are ignored.

## Timing
- Accept at edge k. Macro samples at k+½. Q is valid by k+½+45 ns and captured at edge k+2. RSP_VALID is high during cycle k+2..k+3.
- Throughput: one request per 2 cycles. REQ_READY pattern is 1,0,1,0 under continuous VALID.
- A new request accepted at edge k+2 coincides with the capture. Its macro edge is k+2½, so the captured Q is not corrupted.
- Minimum CLK period 55.6 ns (macro Tcyc), with each phase ≥ 25 ns.
- Reset while a read is pending (any cycle): RSP_VALID stays 0, rd_pend is cleared, pins are deselected at the reset edge, and the FSM returns to INIT. A macro cycle already issued completes. Memory content outside that word is unaffected.
- Reset during CLEAR: clearing restarts from address 0 after INIT.

## Test plan
- Reset, CLEAR_ON_INIT=1, INIT_CYCLES=4 → SRAM_CEN=1 for 4 cycles, then 64 writes A=0..63 with WEN=00, then INIT_DONE=1 and REQ_READY=1 at cycle 4+64+1.
- Write addr 63 data 8'hA5 mask 8'hFF, then read addr 63 → RSP_VALID exactly 2 edges after the read is accepted, RSP_RDATA=8'hA5. Read addr 5 → 8'h00.
- Write 8'h0F mask 8'h0F over 8'hA5 at addr 10, then read → 8'hAF. Write with mask 8'h00 → SRAM_CEN stays 1, a later read of addr 10 still returns 8'hAF.
- Continuous REQ_VALID with alternating reads of addrs 1,2,3 (preloaded 8'h11, 8'h22, 8'h33) → REQ_READY toggles 1,0. Responses arrive 11, 22, 33 in order, each one cycle wide.
- Assert RSTN=0 in the cycle after a read is accepted → no RSP_VALID, SRAM_CEN=1 at the next edge. INIT restarts and INIT_DONE=0.
- CLEAR_ON_INIT=0 → no writes during init, INIT_DONE after INIT_CYCLES. The first read returns the macro's power-up content (8'h00).

Source files
------------

// File: rtl/gf180mcu_sram64x8_ctrl_if.sv
// Request/response port of the gf180mcu 64x8 SRAM controller.
// The master issues requests and the slave (controller) answers reads with a strobe.
interface gf180mcu_sram64x8_ctrl_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [5:0] req_addr;
   logic [7:0] req_wdata;
   logic [7:0] req_wmask;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wmask,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wmask,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/gf180mcu_sram64x8_ctrl.sv
// Controller for the gf180mcu_fd_ip_sram__sram64x8m8wm1 macro: power-up CEN sequencing,
// optional zero-fill, then one registered macro cycle per accepted request.
module gf180mcu_sram64x8_ctrl #(
   parameter int unsigned INIT_CYCLES   = 4,
   parameter bit          CLEAR_ON_INIT = 1'b1
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   gf180mcu_sram64x8_ctrl_if.slave        req,
   output logic                           init_done_o,
   output logic                           sram_cen_o,
   output logic                           sram_gwen_o,
   output logic [7:0]                     sram_wen_o,
   output logic [5:0]                     sram_a_o,
   output logic [7:0]                     sram_d_o,
   input  logic [7:0]                     sram_q_i
);

   localparam int unsigned CW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(INIT_CYCLES - 1);

   typedef enum logic [1:0] {INIT, CLEAR, IDLE, WAIT} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [6:0]    clr_q, clr_d;
   logic          ready_q, ready_d;
   logic          done_q, done_d;
   logic          cen_q, cen_d;
   logic          gwen_q, gwen_d;
   logic [7:0]    wen_q, wen_d;
   logic [5:0]    a_q, a_d;
   logic [7:0]    d_q, d_d;
   logic [1:0]    pend_q, pend_d;
   logic          rvalid_q, rvalid_d;
   logic [7:0]    rdata_q, rdata_d;

   // Pins default to deselected every cycle so each access lasts exactly one macro edge.
   // Read data is captured two edges after acceptance, once the macro falling edge has
   // produced Q; the intervening deselected cycle keeps Q stable for the capture.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      clr_d    = clr_q;
      ready_d  = 1'b0;
      done_d   = done_q;
      cen_d    = 1'b1;
      gwen_d   = 1'b1;
      wen_d    = 8'hFF;
      a_d      = a_q;
      d_d      = d_q;
      pend_d   = {pend_q[0], 1'b0};
      rvalid_d = pend_q[1];
      rdata_d  = pend_q[1] ? sram_q_i : rdata_q;

      unique case (state_q)
         INIT: begin
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (CLEAR_ON_INIT) begin
                  state_d = CLEAR;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
                  ready_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         CLEAR: begin
            if (clr_q[6]) begin
               state_d = IDLE;
               done_d  = 1'b1;
               ready_d = 1'b1;
               clr_d   = '0;
            end else begin
               cen_d  = 1'b0;
               gwen_d = 1'b0;
               wen_d  = 8'h00;
               a_d    = clr_q[5:0];
               d_d    = 8'h00;
               clr_d  = clr_q + 7'd1;
            end
         end
         IDLE: begin
            ready_d = 1'b1;
            if (req.req_valid && ready_q) begin
               // A fully masked write is accepted but never reaches the macro.
               ready_d   = 1'b0;
               state_d   = WAIT;
               a_d       = req.req_addr;
               d_d       = req.req_wdata;
               wen_d     = ~req.req_wmask;
               gwen_d    = ~req.req_write;
               cen_d     = req.req_write && (req.req_wmask == 8'h00);
               pend_d[0] = ~req.req_write;
            end
         end
         WAIT: begin
            ready_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= INIT;
         cnt_q    <= '0;
         clr_q    <= '0;
         ready_q  <= 1'b0;
         done_q   <= 1'b0;
         cen_q    <= 1'b1;
         gwen_q   <= 1'b1;
         wen_q    <= 8'hFF;
         a_q      <= 6'd0;
         d_q      <= 8'h00;
         pend_q   <= 2'b00;
         rvalid_q <= 1'b0;
         rdata_q  <= 8'h00;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         clr_q    <= clr_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
         cen_q    <= cen_d;
         gwen_q   <= gwen_d;
         wen_q    <= wen_d;
         a_q      <= a_d;
         d_q      <= d_d;
         pend_q   <= pend_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   assign req.req_ready = ready_q;
   assign req.rsp_valid = rvalid_q;
   assign req.rsp_rdata = rdata_q;
   assign init_done_o   = done_q;
   assign sram_cen_o    = cen_q;
   assign sram_gwen_o   = gwen_q;
   assign sram_wen_o    = wen_q;
   assign sram_a_o      = a_q;
   assign sram_d_o      = d_q;

endmodule

// File: tb/tb_gf180mcu_sram64x8_ctrl.sv
// Bench for gf180mcu_sram64x8_ctrl: behavioural macro on the falling edge, an expected-memory
// model driven by randomized requests, plus a second instance without zero-fill.
module tb_gf180mcu_sram64x8_ctrl;

   localparam int INIT1 = 4;
   localparam int INIT2 = 3;
   localparam int CLEAR_EDGES = INIT1 + 64 + 1;

   logic clk = 1'b0;
   logic rstn;
   logic rstn2;
   int   testsRun = 0;
   int   testsFailed = 0;

   // Clock
   always #10 clk = ~clk;

   gf180mcu_sram64x8_ctrl_if rq ();
   gf180mcu_sram64x8_ctrl_if rq2 ();

   logic       initDone, sramCen, sramGwen;
   logic [7:0] sramWen, sramD;
   logic [5:0] sramA;
   logic [7:0] sramQ = 8'h5A;
   logic       initDone2, sramCen2, sramGwen2;
   logic [7:0] sramWen2, sramD2;
   logic [5:0] sramA2;
   logic [7:0] sramQ2 = 8'h5A;

   gf180mcu_sram64x8_ctrl #(.INIT_CYCLES(INIT1), .CLEAR_ON_INIT(1'b1)) dut (
      .clk_i(clk), .rst_ni(rstn), .req(rq.slave), .init_done_o(initDone),
      .sram_cen_o(sramCen), .sram_gwen_o(sramGwen), .sram_wen_o(sramWen),
      .sram_a_o(sramA), .sram_d_o(sramD), .sram_q_i(sramQ)
   );

   gf180mcu_sram64x8_ctrl #(.INIT_CYCLES(INIT2), .CLEAR_ON_INIT(1'b0)) dut2 (
      .clk_i(clk), .rst_ni(rstn2), .req(rq2.slave), .init_done_o(initDone2),
      .sram_cen_o(sramCen2), .sram_gwen_o(sramGwen2), .sram_wen_o(sramWen2),
      .sram_a_o(sramA2), .sram_d_o(sramD2), .sram_q_i(sramQ2)
   );

   // Macro behaviour: samples on the falling controller edge, random power-up content for
   // the first instance so the zero-fill is observable, zero content for the second.
   logic [7:0] macroMem [64];
   logic [7:0] macroMem2 [64] = '{default: 8'h00};
   bit         memSeeded = 1'b0;

   always @(negedge clk) begin
      if (!memSeeded) begin
         for (int i = 0; i < 64; i++) macroMem[i] <= 8'($urandom);
         memSeeded <= 1'b1;
      end else if (!sramCen) begin
         if (!sramGwen) macroMem[sramA] <= (macroMem[sramA] & sramWen) | (sramD & ~sramWen);
         else           sramQ <= macroMem[sramA];
      end
   end

   always @(negedge clk) begin
      if (!sramCen2) begin
         if (!sramGwen2) macroMem2[sramA2] <= (macroMem2[sramA2] & sramWen2) | (sramD2 & ~sramWen2);
         else            sramQ2 <= macroMem2[sramA2];
      end
   end

   // Reference contents of the memory as the requester should see it.
   logic [7:0] expMem [64];

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Releases reset and follows the init/zero-fill schedule edge by edge.
   task automatic checkInitSequence(input int stopAt);
      rstn = 1'b1;
      for (int i = 1; i <= stopAt; i++) begin
         @(posedge clk); #1;
         if (i <= INIT1)
            checkOutput("initHold", 64'({sramCen, sramGwen, sramWen, rq.req_ready, initDone}),
                        64'({1'b1, 1'b1, 8'hFF, 1'b0, 1'b0}));
         else if (i < CLEAR_EDGES)
            checkOutput("clearWrite", 64'({sramCen, sramGwen, sramWen, sramA, sramD, rq.req_ready, initDone}),
                        64'({1'b0, 1'b0, 8'h00, 6'(i - INIT1 - 1), 8'h00, 1'b0, 1'b0}));
         else
            checkOutput("initDone", 64'({sramCen, sramGwen, sramWen, rq.req_ready, initDone}),
                        64'({1'b1, 1'b1, 8'hFF, 1'b1, 1'b1}));
      end
      if (stopAt >= CLEAR_EDGES)
         for (int i = 0; i < 64; i++) expMem[i] = 8'h00;
   endtask

   task automatic applyStimulus(input bit write, input logic [5:0] addr, input logic [7:0] wdata,
                                input logic [7:0] wmask);
      int         waited;
      logic [7:0] expData;
      rq.req_valid = 1'b1;
      rq.req_write = write;
      rq.req_addr  = addr;
      rq.req_wdata = wdata;
      rq.req_wmask = wmask;
      waited = 0;
      while (!rq.req_ready && waited < 16) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!rq.req_ready) begin
         checkOutput("acceptTimeout", 64'(rq.req_ready), 64'(1'b1));
         rq.req_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      rq.req_valid = 1'b0;
      if (write && wmask == 8'h00)
         checkOutput("maskZeroCen", 64'(sramCen), 64'(1'b1));
      else
         checkOutput("issuePins", 64'({sramCen, sramGwen, sramWen, sramA, sramD}),
                     64'({1'b0, ~write, ~wmask, addr, wdata}));
      checkOutput("readyDrop", 64'(rq.req_ready), 64'(1'b0));
      checkOutput("rspEarly", 64'(rq.rsp_valid), 64'(1'b0));
      if (write) expMem[addr] = (expMem[addr] & ~wmask) | (wdata & wmask);
      expData = expMem[addr];
      @(posedge clk); #1;
      checkOutput("deselect", 64'({sramCen, rq.rsp_valid}), 64'({1'b1, 1'b0}));
      @(posedge clk); #1;
      if (!write) begin
         checkOutput("rspValid", 64'(rq.rsp_valid), 64'(1'b1));
         checkOutput("rspData", 64'(rq.rsp_rdata), 64'(expData));
      end else begin
         checkOutput("noWriteRsp", 64'(rq.rsp_valid), 64'(1'b0));
      end
      @(posedge clk); #1;
      checkOutput("rspOneCycle", 64'(rq.rsp_valid), 64'(1'b0));
      if (!write) checkOutput("rspHold", 64'(rq.rsp_rdata), 64'(expData));
   endtask

   initial begin
      logic [5:0] burstAddr [3] = '{6'd1, 6'd2, 6'd3};
      int         rspIter [$];
      logic [7:0] rspData [$];
      bit         prevAcc;
      int         nAcc;
      int         waited;

      rstn = 1'b0;
      rstn2 = 1'b0;
      rq.req_valid = 1'b0;  rq.req_write = 1'b0;  rq.req_addr = 6'd0;
      rq.req_wdata = 8'h00; rq.req_wmask = 8'h00;
      rq2.req_valid = 1'b0; rq2.req_write = 1'b0; rq2.req_addr = 6'd0;
      rq2.req_wdata = 8'h00; rq2.req_wmask = 8'h00;
      for (int i = 0; i < 64; i++) expMem[i] = 8'hXX;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("resetState",
                  64'({rq.req_ready, rq.rsp_valid, rq.rsp_rdata, initDone, sramCen, sramGwen, sramWen, sramA, sramD}),
                  64'({1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 6'd0, 8'h00}));

      // Interrupted zero-fill must restart from address 0.
      checkInitSequence(30);
      rstn = 1'b0;
      @(posedge clk); #1;
      checkOutput("clearAbort", 64'({sramCen, initDone}), 64'({1'b1, 1'b0}));
      checkInitSequence(CLEAR_EDGES);

      applyStimulus(1'b1, 6'd63, 8'hA5, 8'hFF);
      applyStimulus(1'b0, 6'd63, 8'h00, 8'h00);
      applyStimulus(1'b0, 6'd5,  8'h00, 8'hFF);
      applyStimulus(1'b1, 6'd10, 8'hA5, 8'hFF);
      applyStimulus(1'b1, 6'd10, 8'h0F, 8'h0F);
      applyStimulus(1'b0, 6'd10, 8'h00, 8'h00);
      applyStimulus(1'b1, 6'd10, 8'h55, 8'h00);
      applyStimulus(1'b0, 6'd10, 8'h00, 8'h00);
      checkOutput("maskedMergeModel", 64'(expMem[10]), 64'(8'hAF));

      applyStimulus(1'b1, 6'd1, 8'h11, 8'hFF);
      applyStimulus(1'b1, 6'd2, 8'h22, 8'hFF);
      applyStimulus(1'b1, 6'd3, 8'h33, 8'hFF);

      // Back-to-back reads under continuous valid.
      rq.req_write = 1'b0;
      rq.req_addr  = burstAddr[0];
      rq.req_valid = 1'b1;
      prevAcc = 1'b0;
      nAcc = 0;
      for (int c = 0; c < 10; c++) begin
         checkOutput("burstReady", 64'(rq.req_ready), 64'(!prevAcc));
         if (rspIter.size() > 0 && rspIter[0] == c) begin
            checkOutput("burstRspValid", 64'(rq.rsp_valid), 64'(1'b1));
            checkOutput("burstRspData", 64'(rq.rsp_rdata), 64'(rspData[0]));
            void'(rspIter.pop_front());
            void'(rspData.pop_front());
         end else begin
            checkOutput("burstRspIdle", 64'(rq.rsp_valid), 64'(1'b0));
         end
         prevAcc = rq.req_valid && rq.req_ready;
         if (prevAcc) begin
            rspIter.push_back(c + 3);
            rspData.push_back(expMem[rq.req_addr]);
            nAcc++;
         end
         @(posedge clk); #1;
         if (prevAcc) begin
            if (nAcc < 3) rq.req_addr = burstAddr[nAcc];
            else          rq.req_valid = 1'b0;
         end
      end
      checkOutput("burstAccepted", 64'(nAcc), 64'(3));
      checkOutput("burstDrained", 64'(rspIter.size()), 64'(0));
      checkOutput("burstOrderModel", 64'({expMem[1], expMem[2], expMem[3]}), 64'(24'h112233));

      for (int n = 0; n < 40; n++)
         applyStimulus(1'($urandom), 6'($urandom_range(0, 15)), 8'($urandom),
                       ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));

      // Reset lands in the cycle after a read is accepted.
      rq.req_write = 1'b0;
      rq.req_addr  = 6'd63;
      rq.req_valid = 1'b1;
      waited = 0;
      while (!rq.req_ready && waited < 16) begin
         @(posedge clk); #1;
         waited++;
      end
      checkOutput("rstReadReady", 64'(rq.req_ready), 64'(1'b1));
      @(posedge clk); #1;
      rq.req_valid = 1'b0;
      rstn = 1'b0;
      @(posedge clk); #1;
      checkOutput("rstMidRead",
                  64'({sramCen, sramGwen, sramWen, rq.rsp_valid, rq.rsp_rdata, initDone, rq.req_ready}),
                  64'({1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0}));
      @(posedge clk); #1;
      checkOutput("rstNoRsp", 64'(rq.rsp_valid), 64'(1'b0));
      checkInitSequence(CLEAR_EDGES);
      applyStimulus(1'b0, 6'd63, 8'h00, 8'h00);
      applyStimulus(1'b0, 6'($urandom), 8'h00, 8'h00);

      // Second instance: no zero-fill, ready straight after INIT.
      checkOutput("reset2", 64'({rq2.req_ready, rq2.rsp_valid, initDone2, sramCen2, sramWen2}),
                  64'({1'b0, 1'b0, 1'b0, 1'b1, 8'hFF}));
      rstn2 = 1'b1;
      for (int i = 1; i <= INIT2 + 2; i++) begin
         @(posedge clk); #1;
         checkOutput("init2", 64'({sramCen2, rq2.req_ready, initDone2}),
                     64'({1'b1, (i >= INIT2), (i >= INIT2)}));
      end
      rq2.req_write = 1'b0;
      rq2.req_addr  = 6'($urandom);
      rq2.req_valid = 1'b1;
      @(posedge clk); #1;
      rq2.req_valid = 1'b0;
      checkOutput("issue2", 64'({sramCen2, sramGwen2, sramA2}), 64'({1'b0, 1'b1, rq2.req_addr}));
      @(posedge clk); #1;
      checkOutput("rspEarly2", 64'(rq2.rsp_valid), 64'(1'b0));
      @(posedge clk); #1;
      checkOutput("rsp2", 64'({rq2.rsp_valid, rq2.rsp_rdata}), 64'({1'b1, 8'h00}));

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
